// File: rtl/lsu_ctrl.sv
// Load/store controller in front of an 8-entry data memory with combinational read.
// One request at a time; add and swap complete as a single-cycle read-modify-write.
module lsu_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [2:0]   req_addr,
    input  logic [W-1:0] req_wdata,
    output logic [2:0]   mem_address,
    output logic [W-1:0] mem_data_in,
    output logic         mem_w_en,
    input  logic [W-1:0] mem_data_out,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic [7:0]   op_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;

    logic [1:0]   state;
    logic [1:0]   op_p0;
    logic [2:0]   addr_p0;
    logic [W-1:0] wdata_p0;
    logic [W-1:0] rsp_data_p1;
    logic         exec;

    // Modular sum; the carry out of the top bit is dropped on purpose.
    function automatic logic [W-1:0] wrap_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] full;
        full = {1'b0, a} + {1'b0, b};
        return full[W-1:0];
    endfunction

    // Stage p0: request capture and FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op_p0       <= OP_LOAD;
            addr_p0     <= '0;
            wdata_p0    <= '0;
            rsp_data_p1 <= '0;
            op_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_p0    <= req_op;
                        addr_p0  <= req_addr;
                        wdata_p0 <= req_wdata;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (op_p0 == OP_STORE) begin
                        op_count <= op_count + 8'd1;
                        state    <= IDLE;
                    end else begin
                        // Captured in the write cycle, so this is the pre-write value.
                        rsp_data_p1 <= mem_data_out;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        op_count <= op_count + 8'd1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage p1: memory drive and response
    assign exec        = (state == EXEC);
    assign req_ready   = (state == IDLE);
    assign rsp_valid   = (state == RESP);
    assign rsp_data    = rsp_data_p1;
    assign mem_address = addr_p0;
    assign mem_w_en    = exec && (op_p0 != OP_LOAD);
    assign mem_data_in = (exec && op_p0 == OP_ADD) ? wrap_add(mem_data_out, wdata_p0) : wdata_p0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a behavioural 8-entry memory and a shadow
// model of its contents used to predict every response.
module tb_lsu_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [2:0] req_addr;
    logic [7:0] req_wdata;
    logic [2:0] mem_address;
    logic [7:0] mem_data_in;
    logic       mem_w_en;
    logic [7:0] mem_data_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [7:0] op_count;

    logic [7:0] mem [8];
    logic [7:0] expm [8];
    logic       preload;
    logic [7:0] exp_cnt;
    int         wen_cnt;
    int         total;
    int         bad;

    lsu_ctrl #(.W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_w_en     (mem_w_en),
        .mem_data_out (mem_data_out),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .op_count     (op_count)
    );

    always #5 clk = ~clk;

    assign mem_data_out = mem[mem_address];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 8; i++) mem[i] <= 8'(i);
        end else if (mem_w_en) begin
            mem[mem_address] <= mem_data_in;
        end
    end

    always @(posedge clk) begin
        if (mem_w_en) wen_cnt = wen_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request and follow it to completion; hold = cycles of rsp_ready low.
    task automatic run_op(input logic [1:0] op, input logic [2:0] addr, input logic [7:0] wd,
                          input int hold);
        int         w0;
        int         t;
        logic [7:0] exp_rsp;
        t = 0;
        while (!req_ready && t < 20) begin
            @(posedge clk); #1; t++;
        end
        chk("idle_ready", req_ready, 1);
        exp_rsp = expm[addr];
        w0 = wen_cnt;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        rsp_ready = (hold == 0);
        @(posedge clk); #1;
        req_valid = 1'b0; req_wdata = ~wd;
        chk("exec_wen", mem_w_en, (op != 2'b00));
        chk("exec_addr", mem_address, addr);
        chk("exec_ready", req_ready, 0);
        case (op)
            2'b01: begin chk("exec_wd_st", mem_data_in, wd); expm[addr] = wd; end
            2'b10: begin chk("exec_wd_add", mem_data_in, 8'(exp_rsp + wd)); expm[addr] = 8'(exp_rsp + wd); end
            2'b11: begin chk("exec_wd_sw", mem_data_in, wd); expm[addr] = wd; end
            default: ;
        endcase
        @(posedge clk); #1;
        if (op == 2'b01) begin
            chk("st_ready", req_ready, 1);
            chk("st_norsp", rsp_valid, 0);
        end else begin
            for (int i = 0; i < hold; i++) begin
                chk("hold_valid", rsp_valid, 1);
                chk("hold_data", rsp_data, exp_rsp);
                chk("hold_ready", req_ready, 0);
                chk("hold_wen", mem_w_en, 0);
                @(posedge clk); #1;
            end
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_data", rsp_data, exp_rsp);
            chk("rsp_wdin", mem_data_in, wd);
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            chk("rsp_done", rsp_valid, 0);
            chk("rsp_idle", req_ready, 1);
        end
        exp_cnt = exp_cnt + 8'd1;
        chk("op_count", op_count, exp_cnt);
        chk("wen_pulses", wen_cnt - w0, (op != 2'b00) ? 1 : 0);
        chk("mem_model", mem[addr], expm[addr]);
    endtask

    initial begin
        total = 0; bad = 0; wen_cnt = 0; exp_cnt = 8'd0;
        rst = 1'b1; preload = 1'b1;
        req_valid = 1'b0; req_op = 2'b00; req_addr = 3'd0; req_wdata = 8'd0; rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) expm[i] = 8'(i);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_rspv", rsp_valid, 0);
        chk("rst_rspd", rsp_data, 0);
        chk("rst_wen", mem_w_en, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_din", mem_data_in, 0);
        chk("rst_cnt", op_count, 0);
        preload = 1'b0; rst = 1'b0;
        @(posedge clk); #1;

        run_op(2'b00, 3'd5, 8'h00, 0);
        run_op(2'b01, 3'd2, 8'hA5, 0);
        run_op(2'b00, 3'd2, 8'h00, 0);
        chk("store_load", expm[2], 8'hA5);
        run_op(2'b10, 3'd3, 8'hFE, 0);
        run_op(2'b00, 3'd3, 8'h00, 0);
        chk("add_wrap", mem[3], 8'h01);
        run_op(2'b11, 3'd7, 8'h3C, 5);
        run_op(2'b00, 3'd7, 8'h00, 0);
        chk("swap_val", mem[7], 8'h3C);

        // Asynchronous reset during the EXEC cycle of a store to address 4.
        req_valid = 1'b1; req_op = 2'b01; req_addr = 3'd4; req_wdata = 8'h99;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("ar_exec_wen", mem_w_en, 1);
        #2; rst = 1'b1; #1;
        chk("ar_wen", mem_w_en, 0);
        chk("ar_rspv", rsp_valid, 0);
        chk("ar_ready", req_ready, 1);
        chk("ar_cnt", op_count, 0);
        chk("ar_addr", mem_address, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 8'd0;
        @(posedge clk); #1;
        chk("ar_mem4", mem[4], 8'h04);
        chk("ar_idle", req_ready, 1);

        for (int n = 0; n < 256; n++) run_op(2'b00, 3'(n), 8'h00, 0);
        chk("wrap_cnt", op_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

endmodule
